// File: rtl/rv_mc_core_if.sv
// Instruction-fetch bus between rv_mc_core (master) and instruction memory (slave).
// Handshake: the master raises imem_req with a stable imem_addr and holds both until the
// first cycle in which imem_ack=1; that cycle is the transfer and imem_rdata is valid in it.
interface rv_mc_core_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/rv_mc_core.sv
// Multicycle RV32I-subset core (ADD/SUB/ADDI/SLLI/SRLI/SRAI/BEQ/BNE/LUI) producing a
// per-instruction retire stream; FETCH -> EXEC -> RETIRE, HALT on illegal/misaligned.
module rv_mc_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  rv_mc_core_if.master imem,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        rdv,
  output logic [4:0]  rd_x,
  output logic [31:0] rd_data,
  output logic        pcv,
  output logic [31:0] pc_x,
  output logic        halted,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_RETIRE, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, ir_q, res_q, tgt_q;
  logic        wr_q, br_q, exc_q;
  logic [31:0] rf [32];

  logic [4:0]  opc, rs1, rs2, rd, shamt;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] a, b, imm_i, imm_b, target, result;
  logic        legal, writes, taken;

  assign opc   = ir_q[6:2];
  assign rd    = ir_q[11:7];
  assign f3    = ir_q[14:12];
  assign rs1   = ir_q[19:15];
  assign rs2   = ir_q[24:20];
  assign shamt = ir_q[24:20];
  assign f7    = ir_q[31:25];
  assign a     = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign b     = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign target = pc_q + imm_b;

  // Decode and execute; anything not matched below stays illegal.
  always_comb begin
    legal  = 1'b0;
    writes = 1'b0;
    taken  = 1'b0;
    result = '0;
    if (ir_q[1:0] == 2'b11) begin
      case (opc)
        5'b01100: begin
          if (f3 == 3'b000 && (f7 == 7'h00 || f7 == 7'h20)) begin
            legal  = 1'b1;
            writes = 1'b1;
            result = f7[5] ? (a - b) : (a + b);
          end
        end
        5'b00100: begin
          case (f3)
            3'b000: begin
              legal  = 1'b1;
              writes = 1'b1;
              result = a + imm_i;
            end
            3'b001: begin
              if (f7 == 7'h00) begin
                legal  = 1'b1;
                writes = 1'b1;
                result = a << shamt;
              end
            end
            3'b101: begin
              if (f7 == 7'h00) begin
                legal  = 1'b1;
                writes = 1'b1;
                result = a >> shamt;
              end else if (f7 == 7'h20) begin
                legal  = 1'b1;
                writes = 1'b1;
                result = 32'($signed(a) >>> shamt);
              end
            end
            default: ;
          endcase
        end
        5'b11000: begin
          if (f3 == 3'b000 || f3 == 3'b001) begin
            legal = 1'b1;
            taken = (a == b) ^ f3[0];
          end
        end
        5'b01101: begin
          legal  = 1'b1;
          writes = 1'b1;
          result = {ir_q[31:12], 12'b0};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (imem.imem_ack) state_d = S_EXEC;
      S_EXEC:   state_d = S_RETIRE;
      S_RETIRE: state_d = exc_q ? S_HALT : S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      res_q   <= '0;
      tgt_q   <= '0;
      wr_q    <= 1'b0;
      br_q    <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && imem.imem_ack) ir_q <= imem.imem_rdata;
      if (state_q == S_EXEC) begin
        res_q <= result;
        tgt_q <= target;
        wr_q  <= legal && writes && (rd != 5'd0);
        br_q  <= taken && !target[1];
        exc_q <= !legal || (taken && target[1]);
      end
      // A faulting instruction leaves the PC pointing at itself.
      if (state_q == S_RETIRE && !exc_q) pc_q <= br_q ? tgt_q : (pc_q + 32'd4);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (state_q == S_RETIRE && wr_q) begin
      rf[rd] <= res_q;
    end
  end

  assign imem.imem_req  = reset && (state_q == S_FETCH);
  assign imem.imem_addr = pc_q;

  assign valid     = (state_q == S_RETIRE);
  assign rdv       = valid && wr_q;
  assign pcv       = valid && br_q;
  assign pc        = valid ? pc_q : 32'd0;
  assign inst      = valid ? ir_q : 32'd0;
  assign rd_x      = rdv ? rd : 5'd0;
  assign rd_data   = rdv ? res_q : 32'd0;
  assign pc_x      = pcv ? tgt_q : 32'd0;
  assign halted    = (state_q == S_HALT);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_rv_mc_core.sv
// Randomized bench for rv_mc_core: memory responder + instruction-level reference model feed
// an expected-retire queue; a monitor pops and compares on every valid pulse.
module tb_rv_mc_core;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int W = 135;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid, rdv, pcv, halted;
  logic [31:0] pc, inst, rd_data, pc_x;
  logic [4:0]  rd_x;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  rv_mc_core_if bus ();

  rv_mc_core #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .imem(bus),
    .valid(valid), .pc(pc), .inst(inst), .rdv(rdv), .rd_x(rd_x), .rd_data(rd_data),
    .pcv(pcv), .pc_x(pc_x), .halted(halted), .state_dbg(state_dbg)
  );

  logic [31:0]  mem [64];
  logic [31:0]  m_x [32];
  logic [31:0]  m_pc;
  bit           m_halt;
  logic [W-1:0] exp_q [$];
  int checks = 0, errors = 0;
  int cycle = 0, retires = 0, last_valid_cyc = -1;
  int min_delay = 0, max_delay = 0, delay_now = 0, wait_cnt = 0, req_run = 0;
  logic [31:0] hold_addr;
  bit prev_valid = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [4:0] rd);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_sh(input logic [6:0] f7, input logic [4:0] sh,
                                         input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, sh, rs1, f3, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  function automatic logic [31:0] fetch_word(input logic [31:0] addr);
    return (addr[31:8] == 24'd0) ? mem[addr[7:2]] : 32'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_x[i] = '0;
    m_pc   = RESET_PC;
    m_halt = 1'b0;
  endtask

  // Architectural step: what the ISA says one instruction does to regs and PC.
  task automatic model_step(input logic [31:0] w);
    logic [31:0] s1, s2, val, tgt, off;
    logic [4:0]  rd;
    bit ok, wr, br, tk;
    ok = 0; wr = 0; br = 0; tk = 0; val = '0;
    rd = w[11:7];
    s1 = m_x[w[19:15]];
    s2 = m_x[w[24:20]];
    off = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    tgt = m_pc + off;
    if (w[6:0] == 7'b0110011 && w[14:12] == 3'd0 && w[31:25] == 7'h00) begin ok = 1; wr = 1; val = s1 + s2; end
    if (w[6:0] == 7'b0110011 && w[14:12] == 3'd0 && w[31:25] == 7'h20) begin ok = 1; wr = 1; val = s1 - s2; end
    if (w[6:0] == 7'b0010011 && w[14:12] == 3'd0) begin ok = 1; wr = 1; val = s1 + {{20{w[31]}}, w[31:20]}; end
    if (w[6:0] == 7'b0010011 && w[14:12] == 3'd1 && w[31:25] == 7'h00) begin ok = 1; wr = 1; val = s1 << w[24:20]; end
    if (w[6:0] == 7'b0010011 && w[14:12] == 3'd5 && w[31:25] == 7'h00) begin ok = 1; wr = 1; val = s1 >> w[24:20]; end
    if (w[6:0] == 7'b0010011 && w[14:12] == 3'd5 && w[31:25] == 7'h20) begin ok = 1; wr = 1; val = 32'($signed(s1) >>> w[24:20]); end
    if (w[6:0] == 7'b0110111) begin ok = 1; wr = 1; val = {w[31:12], 12'd0}; end
    if (w[6:0] == 7'b1100011 && w[14:12] == 3'd0) begin ok = 1; br = 1; tk = (s1 == s2); end
    if (w[6:0] == 7'b1100011 && w[14:12] == 3'd1) begin ok = 1; br = 1; tk = (s1 != s2); end
    if (!ok || (tk && tgt[1])) begin
      exp_q.push_back({m_pc, w, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0});
      m_halt = 1'b1;
    end else begin
      exp_q.push_back({m_pc, w, wr && rd != 0, rd, val, tk, tgt});
      if (wr && rd != 0) m_x[rd] = val;
      m_pc = tk ? tgt : m_pc + 32'd4;
    end
  endtask

  // Memory responder: random ack latency; each accepted fetch is one model step.
  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.imem_ack = 1'b0;
      if (reset && bus.imem_req) begin
        req_run++;
        if (req_run == 1) hold_addr = bus.imem_addr;
        else chk("imem_addr_stable", bus.imem_addr, hold_addr);
        if (wait_cnt == 0) begin
          chk("req_hold_cycles", req_run, delay_now + 1);
          chk("fetch_addr", bus.imem_addr, m_pc);
          chk("fetch_after_halt", m_halt, 0);
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = fetch_word(bus.imem_addr);
          model_step(bus.imem_rdata);
          delay_now = $urandom_range(max_delay, min_delay);
          wait_cnt  = delay_now;
          req_run   = 0;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // Monitor: every retire pulse consumes one expected record.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!valid && (rdv || pcv)) chk("pulse_without_valid", {rdv, pcv}, 0);
      if (valid) begin
        retires++;
        chk("valid_one_cycle", prev_valid, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_retire: pc %h inst %h with no expected record", pc, inst);
        end else begin
          e = exp_q.pop_front();
          chk("retire_pc", pc, e[134:103]);
          chk("retire_inst", inst, e[102:71]);
          chk("retire_rdv", rdv, e[70]);
          if (e[70]) begin
            chk("retire_rd_x", rd_x, e[69:65]);
            chk("retire_rd_data", rd_data, e[64:33]);
          end
          chk("retire_pcv", pcv, e[32]);
          if (e[32]) chk("retire_pc_x", pc_x, e[31:0]);
        end
        if (max_delay == 0 && last_valid_cyc >= 0) chk("valid_spacing", cycle - last_valid_cyc, 3);
        last_valid_cyc = cycle;
      end
      prev_valid = valid;
    end
  end

  task automatic check_reset_outputs();
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_imem_addr", bus.imem_addr, RESET_PC);
    chk("rst_valid", valid, 0);
    chk("rst_rdv", rdv, 0);
    chk("rst_pcv", pcv, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc, 0);
    chk("rst_inst", inst, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_pc_x", pc_x, 0);
  endtask

  // Called at a falling edge; leaves the core in reset with the model cleared.
  task automatic do_reset(input int dmin, input int dmax);
    reset = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs();
    model_reset();
    min_delay = dmin;
    max_delay = dmax;
    delay_now = $urandom_range(dmax, dmin);
    wait_cnt  = delay_now;
    req_run   = 0;
    last_valid_cyc = -1;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    #3;
    chk("halt_reached", halted, 1);
    chk("model_halted", m_halt, 1);
    chk("exp_q_drained", exp_q.size(), 0);
    repeat (6) begin
      @(negedge clk);
      #3;
      chk("halt_no_req", bus.imem_req, 0);
      chk("halt_sticky", halted, 1);
    end
  endtask

  task automatic wait_retires(input int n, input int budget);
    int start = retires;
    int c = 0;
    while (retires - start < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("retire_count", retires - start, n);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0] a, b, d;
    a = 5'($urandom_range(7, 0));
    b = 5'($urandom_range(7, 0));
    d = 5'($urandom_range(7, 0));
    case ($urandom_range(8, 0))
      0: return enc_r(7'h00, b, a, 3'd0, d);
      1: return enc_r(7'h20, b, a, 3'd0, d);
      2: return enc_i(12'($urandom), a, d);
      3: return enc_sh(7'h00, 5'($urandom), a, 3'd1, d);
      4: return enc_sh(7'h00, 5'($urandom), a, 3'd5, d);
      5: return enc_sh(7'h20, 5'($urandom), a, 3'd5, d);
      6: return enc_u(20'($urandom), d);
      7: return enc_b($urandom_range(1, 0) ? 13'd8 : 13'd4, b, a, 3'd0);
      default: return enc_b($urandom_range(1, 0) ? 13'd8 : 13'd4, b, a, 3'd1);
    endcase
  endfunction

  function automatic logic [31:0] rand_end();
    case ($urandom_range(3, 0))
      0: return 32'd0;
      1: return enc_r(7'h01, 5'd1, 5'd2, 3'd0, 5'd3);
      2: return enc_sh(7'h20, 5'd3, 5'd1, 3'd1, 5'd2);
      default: return enc_b(13'd6, 5'd0, 5'd0, 3'd0);
    endcase
  endfunction

  initial begin
    reset = 1'b0;
    repeat (2) @(negedge clk);
    do_reset(0, 0);

    // Arithmetic chain, back-to-back acks.
    mem[0] = enc_u(20'h12345, 5'd1);
    mem[1] = enc_i(12'hFFF, 5'd0, 5'd2);
    mem[2] = enc_sh(7'h20, 5'd4, 5'd2, 3'd5, 5'd3);
    mem[3] = enc_sh(7'h00, 5'd4, 5'd2, 3'd5, 5'd4);
    mem[4] = enc_r(7'h20, 5'd2, 5'd0, 3'd0, 5'd5);
    release_reset();
    wait_halt(100);

    // NOP behind a 5-cycle ack delay.
    @(negedge clk);
    do_reset(5, 5);
    mem[0] = enc_i(12'd0, 5'd0, 5'd0);
    release_reset();
    wait_halt(100);

    // Taken BNE loop back to 0x08.
    @(negedge clk);
    do_reset(0, 2);
    mem[0] = enc_u(20'h1, 5'd1);
    mem[1] = enc_i(12'd0, 5'd0, 5'd0);
    mem[2] = enc_i(12'd1, 5'd9, 5'd9);
    mem[3] = enc_i(12'd0, 5'd0, 5'd0);
    mem[4] = enc_b(-13'sd8, 5'd0, 5'd1, 3'd1);
    release_reset();
    wait_retires(12, 200);

    // Not-taken BEQ falls through, illegal word at 0x20.
    @(negedge clk);
    do_reset(0, 1);
    mem[0] = enc_u(20'h1, 5'd1);
    mem[1] = enc_i(12'd0, 5'd0, 5'd0);
    mem[2] = enc_i(12'd1, 5'd9, 5'd9);
    mem[3] = enc_i(12'd0, 5'd0, 5'd0);
    mem[4] = enc_b(-13'sd8, 5'd0, 5'd1, 3'd0);
    mem[5] = enc_r(7'h00, 5'd9, 5'd1, 3'd0, 5'd7);
    mem[6] = enc_sh(7'h00, 5'd3, 5'd1, 3'd1, 5'd8);
    mem[7] = enc_i(12'd0, 5'd0, 5'd0);
    release_reset();
    wait_halt(200);

    // Taken branch to a misaligned target.
    @(negedge clk);
    do_reset(0, 0);
    mem[0] = enc_i(12'd3, 5'd0, 5'd5);
    mem[1] = enc_b(13'd6, 5'd0, 5'd0, 3'd0);
    release_reset();
    wait_halt(100);

    // Reset while ADDI x6 is in EXEC; the write must not survive.
    @(negedge clk);
    do_reset(0, 0);
    mem[0] = enc_i(12'd5, 5'd0, 5'd6);
    release_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (bus.imem_ack) break;
    end
    @(negedge clk);
    do_reset(0, 0);
    mem[0] = enc_r(7'h00, 5'd0, 5'd6, 3'd0, 5'd7);
    release_reset();
    wait_halt(100);

    // Random programs.
    for (int p = 0; p < 6; p++) begin
      logic [31:0] ew;
      @(negedge clk);
      do_reset(0, p % 4);
      for (int i = 0; i < 24; i++) mem[i] = rand_inst();
      ew = rand_end();
      for (int i = 24; i < 28; i++) mem[i] = ew;
      release_reset();
      wait_halt(600);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
